ext_timebase: RTL

//  Parametrised 125 MHz timebase counter with external-reference monitor. Runs on the
//  DCM-multiplied clock; counts prescaled ticks for event timestamps; measures each

---
 rtl/ext_timebase.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ext_timebase.sv
// ext_timebase: prescaled timestamp counter plus external-reference period monitor.
// The counter and the lock monitor share only the clock; lock never gates counting.
// Optional feature macro: TB_RESYNC_EN (resync realigns the counter to a freqin edge).
`timescale 1ns/1ps
module ext_timebase #(
  parameter int CNT_WIDTH  = 22,
  parameter int PRESCALE   = 2,
  parameter int REF_DIV    = 8,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inhibit,
  input  logic                 freqin,
  input  logic                 resync,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 lock,
  output logic [7:0]           ref_period,
  output logic [15:0]          err_cnt
);

  // PRESCALE=1 still needs a 1-bit prescaler so the compare stays well formed
  localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [7:0]     P_LO    = 8'(REF_DIV - TOL);
  localparam logic [7:0]     P_HI    = 8'(REF_DIV + TOL);
  localparam logic [7:0]     P_TO    = 8'(REF_DIV + TOL + 1);
  localparam logic [7:0]     GC_LOCK = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} st_t;

  logic          s1, s2, s3;
  logic          rise;
  logic          inh_r;
  logic [PW-1:0] pre;
  logic [7:0]    pcnt;
  logic [7:0]    gcnt;
  logic [7:0]    gcnt_inc;
  logic          good;
  logic          timeout;
  logic          bad_evt;
  logic          realign;
  st_t           state, nxt;

  // freqin synchroniser and edge-detect stage
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= freqin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

`ifdef TB_RESYNC_EN
  logic armed;

  // resync arms; the next rise consumes it (a resync on the rise cycle re-arms)
  always_ff @(posedge clk) begin
    if (reset)       armed <= 1'b0;
    else if (resync) armed <= 1'b1;
    else if (rise)   armed <= 1'b0;
  end

  assign realign = rise & armed;
`else
  logic unused_resync;
  assign unused_resync = resync;
  assign realign       = 1'b0;
`endif

  // timestamp counter: realign beats inhibit; inhibit acts one clk late
  always_ff @(posedge clk) begin
    if (reset) begin
      inh_r   <= 1'b0;
      pre     <= '0;
      counter <= '0;
    end else begin
      inh_r <= inhibit;
      if (realign) begin
        pre     <= '0;
        counter <= '0;
      end else if (!inh_r) begin
        if (pre == PRE_MAX) begin
          pre     <= '0;
          counter <= counter + CNT_WIDTH'(1);
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

  // period measurement: pcnt restarts at 1 on each rise, saturates at 255
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt       <= 8'd0;
      ref_period <= 8'd0;
    end else if (rise) begin
      pcnt       <= 8'd1;
      ref_period <= pcnt;
    end else if (pcnt != 8'hFF) begin
      pcnt <= pcnt + 8'd1;
    end
  end

  assign good     = (pcnt >= P_LO) && (pcnt <= P_HI);
  assign timeout  = ~rise && (pcnt == P_TO);
  assign bad_evt  = ((state == ACQUIRE) || (state == LOCKED)) && ((rise && !good) || timeout);
  assign gcnt_inc = gcnt + 8'd1;

  // lock FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= UNLOCKED;
    else       state <= nxt;
  end

  // lock FSM next state
  always_comb begin
    nxt = state;
    case (state)
      UNLOCKED: if (rise) nxt = ACQUIRE;
      ACQUIRE: begin
        if (rise && good) begin
          if (gcnt_inc == GC_LOCK) nxt = LOCKED;
        end else if (timeout) begin
          nxt = UNLOCKED;
        end
      end
      LOCKED:   if ((rise && !good) || timeout) nxt = UNLOCKED;
      default:  nxt = UNLOCKED;
    endcase
  end

  // lock FSM output: decode of the state register
  always_comb begin
    lock = (state == LOCKED);
  end

  // good-period run length and saturating error count
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt    <= 8'd0;
      err_cnt <= 16'd0;
    end else begin
      if (rise && (state == UNLOCKED))     gcnt <= 8'd0;
      else if (rise && (state == ACQUIRE)) gcnt <= good ? gcnt_inc : 8'd0;
      if (bad_evt && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
